// File: rtl/issue_scoreboard_pkg.sv
// Shared pipeline types for the decode/execute issue path.
//   reg_idx_t    : architectural register index
//   issue_req_t  : decoded register usage of one instruction
package issue_scoreboard_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_W    = $clog2(NUM_REGS);

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     uses_rs1;
    logic     uses_rs2;
    logic     writes_rd;
  } issue_req_t;

endpackage : issue_scoreboard_pkg

// File: rtl/issue_scoreboard_sat_counter.sv
// Saturating up-counter for performance events.
//   clk, rst_n : clock, async active-low reset (clears count)
//   inc_i      : count one event this cycle
//   count_o    : registered count, sticks at all-ones
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Hold at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter

// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard between decode and execute.
// Tracks in-flight register writes, blocks issue on RAW/WAW hazards and when
// the outstanding-write cap is reached, and counts stall cycles.
//   instr_valid_i, rs1/rs2/rd_i, uses_*/writes_rd_i : decode request
//   issue_ready_o, stall_o                          : combinational handshake
//   wb_valid_i, wb_rd_i                             : writeback release
//   flush_i                                         : drop all tracking
//   busy_o, outstanding_o, stall_cnt_o, wb_err_o    : registered status
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          BYPASS_WB       = 1'b1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 instr_valid_i,
  input  logic [REG_W-1:0]                     rs1_i,
  input  logic [REG_W-1:0]                     rs2_i,
  input  logic                                 uses_rs1_i,
  input  logic                                 uses_rs2_i,
  input  logic [REG_W-1:0]                     rd_i,
  input  logic                                 writes_rd_i,
  output logic                                 issue_ready_o,
  output logic                                 stall_o,
  input  logic                                 wb_valid_i,
  input  logic [REG_W-1:0]                     wb_rd_i,
  input  logic                                 flush_i,
  output logic [NUM_REGS-1:0]                  busy_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic [CNT_W-1:0]                     stall_cnt_o,
  output logic                                 wb_err_o
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  issue_req_t          req;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [OUT_W-1:0]    outstanding_q, outstanding_d;
  logic                wb_err_q, wb_err_d;

  logic raw1, raw2, waw, full;
  logic rd_live, wb_clear, wb_spurious, issue_fire, ready;

  assign req = '{rs1: rs1_i, rs2: rs2_i, rd: rd_i,
                 uses_rs1: uses_rs1_i, uses_rs2: uses_rs2_i,
                 writes_rd: writes_rd_i};

  // Hazard evaluation; x0 is never busy so it can never raise a hazard.
  always_comb begin
    rd_live     = req.writes_rd && (req.rd != '0);
    wb_clear    = wb_valid_i && (wb_rd_i != '0) && busy_q[wb_rd_i];
    wb_spurious = wb_valid_i && (wb_rd_i != '0) && !busy_q[wb_rd_i];
    raw1 = req.uses_rs1 && (req.rs1 != '0) && busy_q[req.rs1] &&
           !(BYPASS_WB && wb_valid_i && (wb_rd_i == req.rs1));
    raw2 = req.uses_rs2 && (req.rs2 != '0) && busy_q[req.rs2] &&
           !(BYPASS_WB && wb_valid_i && (wb_rd_i == req.rs2));
    waw  = rd_live && busy_q[req.rd];
    // A releasing writeback frees one slot in the same cycle.
    full = rd_live && (outstanding_q == OUT_W'(MAX_OUTSTANDING)) && !wb_clear;
    ready      = !flush_i && !raw1 && !raw2 && !waw && !full;
    issue_fire = instr_valid_i && ready && rd_live;
  end

  // Next-state for busy bitmap, outstanding count and error flag.
  always_comb begin
    busy_d        = busy_q;
    outstanding_d = outstanding_q;
    wb_err_d      = wb_err_q;
    if (flush_i) begin
      busy_d        = '0;
      outstanding_d = '0;
    end else begin
      if (wb_clear) begin
        busy_d[wb_rd_i] = 1'b0;
      end
      // WAW blocks issue to a busy rd, so set never collides with clear.
      if (issue_fire) begin
        busy_d[req.rd] = 1'b1;
      end
      outstanding_d = outstanding_q + OUT_W'(issue_fire) - OUT_W'(wb_clear);
      if (wb_spurious) begin
        wb_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q        <= '0;
      outstanding_q <= '0;
      wb_err_q      <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      wb_err_q      <= wb_err_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (stall_o),
    .count_o (stall_cnt_o)
  );

  assign issue_ready_o = ready;
  assign stall_o       = instr_valid_i && !ready;
  assign busy_o        = busy_q;
  assign outstanding_o = outstanding_q;
  assign wb_err_o      = wb_err_q;

endmodule : issue_scoreboard

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: RAW/bypass, x0, cap, WAW, flush,
// spurious writeback and asynchronous reset.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid_i;
  logic [4:0]  rs1_i, rs2_i, rd_i, wb_rd_i;
  logic        uses_rs1_i, uses_rs2_i, writes_rd_i;
  logic        issue_ready_o, stall_o;
  logic        wb_valid_i, flush_i;
  logic [31:0] busy_o;
  logic [2:0]  outstanding_o;
  logic [15:0] stall_cnt_o;
  logic        wb_err_o;

  int tests = 0;
  int fails = 0;

  issue_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid_i (instr_valid_i),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .uses_rs1_i    (uses_rs1_i),
    .uses_rs2_i    (uses_rs2_i),
    .rd_i          (rd_i),
    .writes_rd_i   (writes_rd_i),
    .issue_ready_o (issue_ready_o),
    .stall_o       (stall_o),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i),
    .flush_i       (flush_i),
    .busy_o        (busy_o),
    .outstanding_o (outstanding_o),
    .stall_cnt_o   (stall_cnt_o),
    .wb_err_o      (wb_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one instruction + writeback + flush at the falling edge.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic wr,
                       input logic wbv, input logic [4:0] wbrd, input logic fl);
    @(negedge clk);
    instr_valid_i = v;  rs1_i = rs1; uses_rs1_i = u1;
    rs2_i = rs2; uses_rs2_i = u2; rd_i = rd; writes_rd_i = wr;
    wb_valid_i = wbv; wb_rd_i = wbrd; flush_i = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  // Outstanding count must always equal the number of busy registers.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("invariant", 64'(outstanding_o), 64'($countones(busy_o)));
    end
  end

  initial begin
    rst_n = 1'b0;
    instr_valid_i = 1'b0; rs1_i = '0; rs2_i = '0; rd_i = '0;
    uses_rs1_i = 1'b0; uses_rs2_i = 1'b0; writes_rd_i = 1'b0;
    wb_valid_i = 1'b0; wb_rd_i = '0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_out", 64'(outstanding_o), 64'h0);
    chk("rst_cnt", 64'(stall_cnt_o), 64'h0);
    chk("rst_err", 64'(wb_err_o), 64'h0);
    chk("rst_ready", 64'(issue_ready_o), 64'h1);
    rst_n = 1'b1;

    // RAW on rs1=5, released by bypassed writeback
    issue_wr(5'd5);
    chk("raw_iss_ready", 64'(issue_ready_o), 64'h1);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("raw_busy5", 64'(busy_o), 64'h20);
    chk("raw_out1", 64'(outstanding_o), 64'h1);
    chk("raw_stall1", 64'(stall_o), 64'h1);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("raw_stall2", 64'(stall_o), 64'h1);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    chk("raw_bypass_ready", 64'(issue_ready_o), 64'h1);
    chk("raw_bypass_stall", 64'(stall_o), 64'h0);
    idle();
    chk("raw_busy_clr", 64'(busy_o), 64'h0);
    chk("raw_out0", 64'(outstanding_o), 64'h0);
    chk("raw_cnt", 64'(stall_cnt_o), 64'd2);
    chk("raw_err", 64'(wb_err_o), 64'h0);

    // x0 write and read, then writeback to x0
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("x0_ready", 64'(issue_ready_o), 64'h1);
    chk("x0_stall", 64'(stall_o), 64'h0);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
    chk("x0_busy", 64'(busy_o), 64'h0);
    chk("x0_out", 64'(outstanding_o), 64'h0);
    idle();
    chk("x0_wb_err", 64'(wb_err_o), 64'h0);

    // Outstanding cap with same-cycle release
    issue_wr(5'd1);
    issue_wr(5'd2);
    issue_wr(5'd3);
    issue_wr(5'd4);
    issue_wr(5'd6);
    chk("cap_out4", 64'(outstanding_o), 64'd4);
    chk("cap_full_ready", 64'(issue_ready_o), 64'h0);
    chk("cap_full_stall", 64'(stall_o), 64'h1);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 5'd2, 1'b0);
    chk("cap_release_ready", 64'(issue_ready_o), 64'h1);
    idle();
    chk("cap_out_still4", 64'(outstanding_o), 64'd4);
    chk("cap_busy", 64'(busy_o), 64'h5A);
    chk("cap_cnt", 64'(stall_cnt_o), 64'd3);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    idle();
    chk("flush1_busy", 64'(busy_o), 64'h0);
    chk("flush1_out", 64'(outstanding_o), 64'h0);

    // WAW on rd=7: no bypass even with same-cycle writeback
    issue_wr(5'd7);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0);
    chk("waw_ready", 64'(issue_ready_o), 64'h0);
    chk("waw_stall", 64'(stall_o), 64'h1);
    issue_wr(5'd7);
    chk("waw_freed_busy", 64'(busy_o), 64'h0);
    chk("waw_next_ready", 64'(issue_ready_o), 64'h1);
    idle();
    chk("waw_busy7", 64'(busy_o), 64'h80);
    chk("waw_out1", 64'(outstanding_o), 64'd1);
    chk("waw_cnt", 64'(stall_cnt_o), 64'd4);

    // Flush with busy 3/9/12, concurrent issue rd=15 and wb rd=9
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd7, 1'b0);
    chk("mix_ready", 64'(issue_ready_o), 64'h1);
    issue_wr(5'd9);
    chk("mix_busy", 64'(busy_o), 64'h8);
    chk("mix_out", 64'(outstanding_o), 64'd1);
    issue_wr(5'd12);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 1'b1, 1'b1, 5'd9, 1'b1);
    chk("fl_pre_busy", 64'(busy_o), 64'h1208);
    chk("fl_ready", 64'(issue_ready_o), 64'h0);
    chk("fl_stall", 64'(stall_o), 64'h1);
    idle();
    chk("fl_busy", 64'(busy_o), 64'h0);
    chk("fl_out", 64'(outstanding_o), 64'h0);
    chk("fl_err", 64'(wb_err_o), 64'h0);
    chk("fl_cnt", 64'(stall_cnt_o), 64'd5);

    // Spurious writeback sets sticky error
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd20, 1'b0);
    idle();
    chk("spur_err", 64'(wb_err_o), 64'h1);
    idle();
    chk("spur_err_sticky", 64'(wb_err_o), 64'h1);

    // Asynchronous reset mid-cycle
    issue_wr(5'd10);
    @(posedge clk);
    #2;
    chk("pre_rst_busy", 64'(busy_o), 64'h400);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy_o), 64'h0);
    chk("arst_out", 64'(outstanding_o), 64'h0);
    chk("arst_cnt", 64'(stall_cnt_o), 64'h0);
    chk("arst_err", 64'(wb_err_o), 64'h0);
    idle();
    rst_n = 1'b1;
    idle();
    chk("post_rst_ready", 64'(issue_ready_o), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_issue_scoreboard
